merge_out_writer: RTL and testbench
===================================

# merge_out_writer

Write-side sink for the P=8 merger tree output. Accepts merged 8-record beats on the tree's write/ready handshake, buffers them in a small beat FIFO, and streams them to the memory write channel as fixed-length bursts at consecutive byte addresses from a programmed base. Detects the end-of-stream terminator record, drains, and reports completion.

## Interface
- DATA_WIDTH, 128, record width in bits
- P, 8, records per beat
- DEPTH, 16, beat FIFO depth (power of two, ≥2)
- BURST, 8, beats per memory burst (power of two)
- ADDR_WIDTH, 32, memory byte-address width
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse, begin a run (honoured only in IDLE)
- i_base_addr  in  ADDR_WIDTH  byte address of first beat, sampled on accepted i_start
- i_write  in  1  tree output write strobe (tree's o_out_fifo_write)
- i_data  in  P*DATA_WIDTH  merged beat, lane 0 in LSBs
- o_ready  out  1  drives tree's i_fifo_out_ready
- o_mem_valid  out  1  memory write beat valid
- o_mem_addr  out  ADDR_WIDTH  byte address of current beat
- o_mem_data  out  P*DATA_WIDTH  beat data
- o_mem_last  out  1  last beat of burst
- i_mem_ready  in  1  memory accepts beat
- o_done  out  1  run complete, held until next accepted i_start
- o_beat_count  out  32  beats accepted by memory this run
- o_err  out  1  sticky overflow flag (see Configuration)

## Operation
- Reset values: o_ready 0, o_mem_valid 0, o_mem_addr 0, o_mem_data 0, o_mem_last 0, o_done 0, o_beat_count 0, o_err 0; state IDLE, FIFO empty, burst counter 0.
- States: IDLE -> RUN on i_start (load address from i_base_addr, clear o_done/o_beat_count/o_err/burst counter). RUN -> DRAIN when the terminal beat is pushed. DRAIN -> DONE when the terminal beat is accepted by memory. DONE -> RUN on i_start.
- Terminal beat: any beat containing an all-zero record in any lane. It is written whole (lanes after the terminator unaltered). Beats after it are never accepted.
- Push: in RUN, o_ready = !fifo_full; push when i_write && o_ready. o_ready = 0 in IDLE, DRAIN, DONE.
- Pop: in RUN/DRAIN, o_mem_valid = !fifo_empty, o_mem_data = FIFO head. On o_mem_valid && i_mem_ready: pop, o_mem_addr += P*DATA_WIDTH/8 (128 default), wraps modulo 2^ADDR_WIDTH; burst counter increments mod BURST; o_beat_count increments.
- o_mem_last = o_mem_valid && (burst counter == BURST-1 || head is terminal beat). Final burst may therefore be short.
- o_mem_valid/o_mem_data hold stable while i_mem_ready is low.
- Simultaneous push and pop: occupancy unchanged; legal when full (o_ready still low that cycle since it depends only on full).
- i_start outside IDLE/DONE ignored. Reset mid-run discards FIFO contents and returns to IDLE.

## Timing
- Pushed beat visible on o_mem_valid the cycle after the push (registered FIFO head); no combinational path i_write -> o_mem_valid.
- o_ready registered-full based: deasserts the cycle after the push that fills the FIFO.
- o_done asserts the cycle after the terminal beat handshake.
- Sustained throughput one beat/cycle when i_mem_ready stays high.

## Configuration
- MERGE_OUT_WRITER_OVF_CHK_EN defined: o_err sets (sticky until i_start or reset) when i_write is high while o_ready is low in RUN; the beat is dropped. Undefined: o_err tied 0, check logic absent; dropped-beat behaviour identical.

## Structure
- Package merge_out_pkg: state enum (IDLE, RUN, DRAIN, DONE), BEAT_BYTES constant, function is_terminal(beat) returning 1 if any lane is zero.
- Sub-module merge_out_fifo: DEPTH x P*DATA_WIDTH synchronous FIFO with full/empty, registered head, async reset.

## Test plan
- Start base 0x1000, push 20 nonzero beats then terminal beat, i_mem_ready=1 -> 21 memory beats at 0x1000..0x1A00, o_mem_last on beats 8, 16, 21, o_done, o_beat_count=21.
- i_mem_ready held 0, tree writes continuously -> exactly 16 beats accepted, o_ready low from cycle after 16th push; release ready -> all 16 drain in order.
- Terminator in lane 3 of beat 5 -> 5 beats written, beat 5 with o_mem_last, further i_write ignored, o_ready 0.
- Base 0xFFFFFF80, 3 beats -> addresses 0xFFFFFF80, 0x00000000, 0x00000080.
- i_write forced while full, macro defined -> o_err=1, beat dropped; macro undefined -> o_err=0.
- Assert i_rst during DRAIN with 4 beats queued -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/merge_out_pkg.sv
// merge_out_pkg: shared types and constants for the merger-tree write-side sink.
//   state_t      : writer run state (IDLE, RUN, DRAIN, DONE)
//   REC_WIDTH    : default record width in bits
//   RECS_PER_BEAT: default records per beat
//   BEAT_BYTES   : default byte stride between consecutive beats
//   is_terminal  : 1 when any record lane of a default-sized beat is all-zero
package merge_out_pkg;

  localparam int unsigned REC_WIDTH     = 128;
  localparam int unsigned RECS_PER_BEAT = 8;
  localparam int unsigned BEAT_BYTES    = RECS_PER_BEAT * REC_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_terminal(input logic [RECS_PER_BEAT*REC_WIDTH-1:0] beat);
    logic term;
    term = 1'b0;
    for (int unsigned i = 0; i < RECS_PER_BEAT; i++) begin
      if (beat[i*REC_WIDTH +: REC_WIDTH] == '0) term = 1'b1;
    end
    return term;
  endfunction

endpackage

// File: rtl/merge_out_fifo.sv
// merge_out_fifo: DEPTH x WIDTH synchronous beat FIFO.
//   clk, rst : clock, asynchronous active-high reset (pointers/occupancy only)
//   push     : write wdata (caller guarantees !full)
//   pop      : drop head (caller guarantees !empty)
//   rdata    : head entry, driven from storage registers only
//   full     : occupancy == DEPTH (registered occupancy)
//   empty    : occupancy == 0     (registered occupancy)
module merge_out_fifo #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/merge_out_writer.sv
// merge_out_writer: sink for the merger-tree output. Buffers merged beats in a
// beat FIFO and writes them to memory as BURST-beat bursts at consecutive
// addresses from i_base_addr; stops after the terminal beat (any all-zero
// record lane) and flags completion.
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_start, i_base_addr    : begin a run (IDLE/DONE only), first beat address
//   i_write, i_data, o_ready: tree-side write/ready handshake
//   o_mem_valid/addr/data/last, i_mem_ready : memory write channel
//   o_done                  : run complete, held until next accepted start
//   o_beat_count            : beats accepted by memory this run
//   o_err                   : sticky overflow (write while not ready in RUN)
// Build option: define MERGE_OUT_WRITER_OVF_CHK_EN to enable o_err; otherwise
// o_err is tied low. Dropped beats are discarded either way.
module merge_out_writer
  import merge_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REC_WIDTH,
  parameter int unsigned P          = RECS_PER_BEAT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BURST      = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic                    i_write,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_mem_valid,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [P*DATA_WIDTH-1:0] o_mem_data,
  output logic                    o_mem_last,
  input  logic                    i_mem_ready,
  output logic                    o_done,
  output logic [31:0]             o_beat_count,
  output logic                    o_err
);

  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(P * DATA_WIDTH / 8);

  function automatic logic any_zero_lane(input logic [P*DATA_WIDTH-1:0] beat);
    logic term;
    term = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      if (beat[i*DATA_WIDTH +: DATA_WIDTH] == '0) term = 1'b1;
    end
    return term;
  endfunction

  state_t state_q, state_d;

  logic                    fifo_full, fifo_empty;
  logic [P*DATA_WIDTH-1:0] head;
  logic                    push, pop, start_ok, head_term, in_term;
  logic [BW-1:0]           burst_q;

  merge_out_fifo #(
    .WIDTH (P * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (i_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_term   = any_zero_lane(head);
  assign in_term     = any_zero_lane(i_data);
  assign start_ok    = i_start && (state_q == IDLE || state_q == DONE);

  assign o_ready     = (state_q == RUN) && !fifo_full;
  assign push        = i_write && o_ready;
  assign o_mem_valid = (state_q == RUN || state_q == DRAIN) && !fifo_empty;
  assign pop         = o_mem_valid && i_mem_ready;
  // Data is masked when idle so the bus sits at zero rather than showing stale storage.
  assign o_mem_data  = o_mem_valid ? head : '0;
  assign o_mem_last  = o_mem_valid && ((burst_q == BW'(BURST - 1)) || head_term);
  assign o_done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (push && in_term) state_d = DRAIN;
      DRAIN:   if (pop && head_term) state_d = DONE;
      DONE:    if (i_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      o_mem_addr   <= '0;
      burst_q      <= '0;
      o_beat_count <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        o_mem_addr   <= i_base_addr;
        burst_q      <= '0;
        o_beat_count <= '0;
      end else if (pop) begin
        o_mem_addr   <= o_mem_addr + ADDR_STEP;
        burst_q      <= burst_q + BW'(1);
        o_beat_count <= o_beat_count + 32'd1;
      end
    end
  end

`ifdef MERGE_OUT_WRITER_OVF_CHK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                      o_err <= 1'b0;
    else if (start_ok)                              o_err <= 1'b0;
    else if (state_q == RUN && i_write && !o_ready) o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_out_writer.sv
module tb_merge_out_writer;

  localparam int DW = 128;
  localparam int NP = 8;
  localparam int BW = NP * DW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [31:0]   i_base_addr;
  logic          i_write;
  logic [BW-1:0] i_data;
  logic          o_ready;
  logic          o_mem_valid;
  logic [31:0]   o_mem_addr;
  logic [BW-1:0] o_mem_data;
  logic          o_mem_last;
  logic          i_mem_ready;
  logic          o_done;
  logic [31:0]   o_beat_count;
  logic          o_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_fold[$];
  logic        mon_last[$];

  merge_out_writer #(
    .DATA_WIDTH (DW),
    .P          (NP),
    .DEPTH      (16),
    .BURST      (8),
    .ADDR_WIDTH (32)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_write      (i_write),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_mem_valid  (o_mem_valid),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_last   (o_mem_last),
    .i_mem_ready  (i_mem_ready),
    .o_done       (o_done),
    .o_beat_count (o_beat_count),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Inputs only change at posedge+1, so the negedge sees what the next posedge will.
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_valid && i_mem_ready) begin
      mon_addr.push_back(o_mem_addr);
      mon_fold.push_back(fold(o_mem_data));
      mon_last.push_back(o_mem_last);
    end
  end

  function automatic logic [31:0] fold(input logic [BW-1:0] d);
    logic [31:0] r;
    r = 32'h1;
    for (int i = 0; i < BW / 32; i++) r = (r * 32'd31) + d[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [BW-1:0] make_beat(input int n);
    logic [BW-1:0] b;
    for (int l = 0; l < NP; l++)
      b[l*DW +: DW] = {64'hC0DE_0000_0000_0000 + 64'(n), 32'(n), 32'(l + 1)};
    return b;
  endfunction

  function automatic logic [BW-1:0] make_term(input int n, input int lane);
    logic [BW-1:0] b;
    b = make_beat(n);
    b[lane*DW +: DW] = '0;
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] base);
    mon_addr.delete();
    mon_fold.delete();
    mon_last.delete();
    i_start     = 1'b1;
    i_base_addr = base;
    step();
    i_start = 1'b0;
  endtask

  task automatic push_beat(input logic [BW-1:0] d);
    int k;
    k = 0;
    i_write = 1'b1;
    i_data  = d;
    while (!o_ready && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) check("push_timeout", 64'd0, 64'd1);
    step();
    i_write = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!o_done && k < 200) begin
      step();
      k++;
    end
    check(tag, 64'(o_done), 64'd1);
  endtask

  // Expected stream: beats make_beat(first+i), the last one terminal in term_lane;
  // last flag every 8th beat and on the terminal beat.
  task automatic compare_stream(input string tag, input int n, input logic [31:0] base,
                                input int first, input int term_lane);
    logic [BW-1:0] d;
    logic [31:0]   a;
    check({tag, "_count"}, 64'(mon_addr.size()), 64'(n));
    for (int i = 0; i < n && i < mon_addr.size(); i++) begin
      d = (i == n - 1) ? make_term(first + i, term_lane) : make_beat(first + i);
      a = base + 32'(i * 128);
      check($sformatf("%s_addr%0d", tag, i), 64'(mon_addr[i]), 64'(a));
      check($sformatf("%s_data%0d", tag, i), 64'(mon_fold[i]), 64'(fold(d)));
      check($sformatf("%s_last%0d", tag, i), 64'(mon_last[i]),
            64'(((i % 8) == 7) || (i == n - 1)));
    end
  endtask

  initial begin
    int acc;
    logic exp_err;
`ifdef MERGE_OUT_WRITER_OVF_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_write = 1'b0;
    i_data = '0; i_mem_ready = 1'b0;
    step(); step();
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_valid", 64'(o_mem_valid), 64'd0);
    check("rst_addr",  64'(o_mem_addr), 64'd0);
    check("rst_data",  64'(fold(o_mem_data)), 64'(fold('0)));
    check("rst_last",  64'(o_mem_last), 64'd0);
    check("rst_done",  64'(o_done), 64'd0);
    check("rst_cnt",   64'(o_beat_count), 64'd0);
    check("rst_err",   64'(o_err), 64'd0);
    i_rst = 1'b0;
    step();
    check("idle_ready", 64'(o_ready), 64'd0);

    // 20 ordinary beats plus terminal, memory always ready.
    i_mem_ready = 1'b1;
    start_run(32'h0000_1000);
    check("t1_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 20; i++) push_beat(make_beat(i));
    push_beat(make_term(20, 7));
    check("t1_drain_ready", 64'(o_ready), 64'd0);
    wait_done("t1_done");
    check("t1_cnt", 64'(o_beat_count), 64'd21);
    compare_stream("t1", 21, 32'h0000_1000, 0, 7);

    // Memory stalled, tree writes every cycle: FIFO fills at 16 and extra beats drop.
    i_mem_ready = 1'b0;
    start_run(32'h0000_2000);
    check("t2_done_clr", 64'(o_done), 64'd0);
    check("t2_cnt_clr",  64'(o_beat_count), 64'd0);
    acc = 0;
    i_write = 1'b1;
    i_data  = make_beat(100);
    for (int c = 0; c < 30; c++) begin
      if (o_ready) begin
        acc++;
        step();
        i_data = make_beat(100 + acc);
      end else begin
        step();
      end
    end
    check("t2_accepted", 64'(acc), 64'd16);
    check("t2_full_ready", 64'(o_ready), 64'd0);
    check("t2_stall_valid", 64'(o_mem_valid), 64'd1);
    check("t2_stall_addr", 64'(o_mem_addr), 64'h2000);
    check("t2_stall_data", 64'(fold(o_mem_data)), 64'(fold(make_beat(100))));
    check("t2_err", 64'(o_err), 64'(exp_err));
    i_write = 1'b0;
    i_mem_ready = 1'b1;
    acc = 0;
    while (mon_addr.size() < 16 && acc < 40) begin
      step();
      acc++;
    end
    check("t2_drained", 64'(mon_addr.size()), 64'd16);
    push_beat(make_term(116, 0));
    wait_done("t2_done");
    check("t2_cnt", 64'(o_beat_count), 64'd17);
    compare_stream("t2", 17, 32'h0000_2000, 100, 0);

    // Terminator in lane 3 of the 5th beat; later writes refused.
    start_run(32'h0000_8000);
    check("t3_err_clr", 64'(o_err), 64'd0);
    for (int i = 0; i < 4; i++) push_beat(make_beat(200 + i));
    push_beat(make_term(204, 3));
    i_write = 1'b1;
    i_data  = make_beat(205);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t3_ready%0d", c), 64'(o_ready), 64'd0);
      step();
    end
    i_write = 1'b0;
    wait_done("t3_done");
    check("t3_cnt", 64'(o_beat_count), 64'd5);
    compare_stream("t3", 5, 32'h0000_8000, 200, 3);

    // Address wrap past 2^32.
    start_run(32'hFFFF_FF80);
    push_beat(make_beat(300));
    push_beat(make_beat(301));
    push_beat(make_term(302, 5));
    wait_done("t4_done");
    compare_stream("t4", 3, 32'hFFFF_FF80, 300, 5);
    if (mon_addr.size() == 3) begin
      check("t4_wrap1", 64'(mon_addr[1]), 64'h0);
      check("t4_wrap2", 64'(mon_addr[2]), 64'h80);
    end

    // Reset while draining with 4 beats queued.
    i_mem_ready = 1'b0;
    start_run(32'h0000_4000);
    for (int i = 0; i < 3; i++) push_beat(make_beat(400 + i));
    push_beat(make_term(403, 1));
    check("t5_drain_ready", 64'(o_ready), 64'd0);
    check("t5_drain_valid", 64'(o_mem_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(o_mem_valid), 64'd0);
    check("t5_rst_addr",  64'(o_mem_addr), 64'd0);
    check("t5_rst_data",  64'(fold(o_mem_data)), 64'(fold('0)));
    check("t5_rst_last",  64'(o_mem_last), 64'd0);
    check("t5_rst_cnt",   64'(o_beat_count), 64'd0);
    check("t5_rst_done",  64'(o_done), 64'd0);
    step();
    i_rst = 1'b0;
    i_mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("t5_idle_valid", 64'(o_mem_valid), 64'd0);
    check("t5_idle_ready", 64'(o_ready), 64'd0);
    check("t5_no_beats", 64'(mon_addr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
